// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
// Request sequencer in front of a 32 x 32-bit single-port synchronous memory
// with registered read data. Read/write burst commands arrive over a
// valid/ready handshake. Write beats arrive over a separate valid/ready
// channel that can stall. Read data is returned with rd_valid, which is
// delayed one cycle to line up with the memory's registered dout.
//
// Build option: define MEM_REQ_CTRL_BURST_EN to honour req_len (1..8 beats).
// Without it every command is a single beat, and req_len is ignored.
//
// Ports:
//   clk, reset_n           clock (rising edge), async active-low reset
//   req_valid/req_ready    command handshake (ready only while idle)
//   req_wr                 1 = write burst, 0 = read burst
//   req_addr, req_len      start address, beats minus one
//   wr_valid/wr_ready      write beat handshake (ready only while writing)
//   wr_data                write beat data
//   rd_valid, rd_data      read beat strobe and data (no backpressure)
//   busy                   burst in progress or read data still pending
//   mem_cen, mem_wen       memory chip enable / write enable
//   mem_addr, mem_din      memory address / write data
//   mem_dout               memory registered read data
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command, req_ready high
// WRITE | issuing one write per accepted wr_valid beat, wr_ready high
// READ  | issuing one read per cycle until the last beat
module mem_req_ctrl #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] beats_left;
    logic [LW-1:0] len_eff;
    logic          accept;
    logic          beat_issue;
    logic          last_beat;

`ifdef MEM_REQ_CTRL_BURST_EN
    assign len_eff = req_len;
`else
    // Single-beat build: the length port stays on the boundary but is unused.
    logic unused_req_len;
    assign unused_req_len = ^req_len;
    assign len_eff        = '0;
`endif

    assign accept     = (state == IDLE) && req_valid;
    assign beat_issue = ((state == WRITE) && wr_valid) || (state == READ);
    assign last_beat  = beat_issue && (beats_left == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_wr ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address wraps modulo 2**AW naturally. beats_left holds at zero on the
    // final beat instead of wrapping, because the FSM leaves the burst there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr   <= '0;
            beats_left <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= (state == READ);
            if (accept) begin
                cur_addr   <= req_addr;
                beats_left <= len_eff;
            end else if (beat_issue) begin
                cur_addr <= cur_addr + 1'b1;
                if (beats_left != '0) begin
                    beats_left <= beats_left - 1'b1;
                end
            end
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        wr_ready  = (state == WRITE);
        mem_cen   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        case (state)
            WRITE: begin
                if (wr_valid) begin
                    mem_cen  = 1'b1;
                    mem_wen  = 1'b1;
                    mem_addr = cur_addr;
                    mem_din  = wr_data;
                end
            end
            READ: begin
                mem_cen  = 1'b1;
                mem_addr = cur_addr;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE) || rd_valid;
    assign rd_data = mem_dout;

endmodule
